led_serial_tx: RTL and testbench
================================

LED_SERIAL_TX -- requirements
Module: led_serial_tx

Interface
REQ-001 The block SHALL have parameter MSB, default 8: word width in bits; legal range MSB >= 2.
REQ-002 The block SHALL have parameter DIV, default 4: number of clk cycles per serial-clock half-period; legal range DIV >= 1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 The block SHALL have port tx_data, input, MSB bits: parallel word to transmit.
REQ-006 The block SHALL have port tx_valid, input, 1 bit: tx_data is valid.
REQ-007 The block SHALL have port tx_ready, output, 1 bit: the block can accept a word.
REQ-008 The block SHALL have port sclk, output, 1 bit: serial clock to the downstream shift register.
REQ-009 The block SHALL have port sdata, output, 1 bit: serial data, MSB first.
REQ-010 The block SHALL have port sen, output, 1 bit: active-low shift enable for the downstream shift register.
REQ-011 The block SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse at end of frame.

Function
REQ-013 The block SHALL register all outputs, with no combinational path from any input to any output.
REQ-014 The block SHALL implement an FSM with states IDLE, LOW, HIGH and HOLD.
REQ-015 In IDLE, the block SHALL drive tx_ready=1, busy=0, sen=1 and sclk=0.
REQ-016 In IDLE, sdata SHALL hold its last value.
REQ-017 A word SHALL be accepted on the edge where tx_valid=1 and tx_ready=1; the block SHALL copy tx_data into an internal shift word and go to LOW.
REQ-018 tx_valid SHALL be ignored while tx_ready=0, and tx_data SHALL be sampled only at acceptance.
REQ-019 From the cycle after acceptance: tx_ready=0, busy=1, sen=0.
REQ-020 In LOW, the block SHALL drive sclk=0 for DIV cycles, with sdata = current bit.
REQ-021 The first LOW phase SHALL present bit MSB-1; each later LOW phase SHALL present the next lower bit.
REQ-022 sdata SHALL change only on entry to LOW, so it is stable across each sclk rising edge.
REQ-023 In HIGH, the block SHALL drive sclk=1 for DIV cycles with sdata unchanged.
REQ-024 At the end of HIGH, the block SHALL go to LOW if bits remain, otherwise to HOLD.
REQ-025 In HOLD, the block SHALL drive sclk=0 and sen=0 for DIV cycles, then go to IDLE.
REQ-026 Frame length SHALL be exactly MSB*2*DIV + DIV cycles with sen=0, containing exactly MSB sclk rising edges.
REQ-027 done SHALL be 1 for exactly the first IDLE cycle after HOLD (the cycle sen returns to 1) and 0 otherwise.
REQ-028 A word accepted in the done cycle SHALL start a new frame on the next cycle, so sen is high for exactly 1 cycle between back-to-back frames.
REQ-029 The divider counter SHALL be ceil(log2(DIV+1)) bits wide and the bit counter ceil(log2(MSB+1)) bits wide.
REQ-030 Neither counter SHALL wrap within a frame, and both SHALL reload at every phase entry.
REQ-031 With DIV=1, the block SHALL produce sclk with period 2 clk cycles and no lost or duplicated bits.

Reset
REQ-032 When reset=0 on a clk edge, the block SHALL set, after that edge: tx_ready=1, busy=0, sen=1, sclk=0, sdata=0, done=0, state=IDLE, both counters 0 and the shift word 0.
REQ-033 A reset mid-frame SHALL abort the frame, with no done pulse and the partial word discarded.
REQ-034 A reset mid-frame SHALL give sen=1 and sclk=0 on the first cycle after the reset edge.
REQ-035 A word SHALL be accepted on the first edge with reset=1.

Verification
REQ-036 The bench SHALL cover single frame: MSB=8, DIV=2, tx_data=0xA5 with one-cycle tx_valid -> downstream model (shifts on sclk rise while sen=0) holds 0xA5; sen low 34 cycles; 8 sclk rises; one done pulse.
REQ-037 The bench SHALL cover back-to-back: 0x3C then 0xC3 presented with tx_valid held high -> both captured in order, sen high exactly 1 cycle between frames, two done pulses.
REQ-038 The bench SHALL cover ignored valid: tx_valid toggled and tx_data changed to 0xFF mid-frame of 0x12 -> 0x12 received, no second frame starts until tx_ready=1.
REQ-039 The bench SHALL cover reset mid-frame: reset=0 for 1 cycle after the 3rd sclk rise of 0x81 -> next cycle sen=1, sclk=0, tx_ready=1, no done; the next word 0x7E is received intact.
REQ-040 The bench SHALL cover DIV=1 edge case: MSB=8, DIV=1, words 0x00, 0xFF and 0x55 -> all received exactly; each frame has sen low 17 cycles.
REQ-041 The bench SHALL cover width: MSB=16, DIV=3, tx_data=0x8001 -> received 0x8001; sen low 99 cycles.

Source files
------------

// File: rtl/led_serial_tx.sv
// Serial word transmitter for a downstream LED shift register.
// Sends MSB first on sclk, framed by the active-low sen, and pulses done as the frame closes.
//
// state | meaning
// IDLE  | ready for a word, sen high, sclk low
// LOW   | sclk low for DIV cycles, current bit on sdata
// HIGH  | sclk high for DIV cycles, sdata held
// HOLD  | sclk low, sen still low for DIV cycles before release
module led_serial_tx #(
  parameter int MSB = 8,
  parameter int DIV = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [MSB-1:0] tx_data,
  input  logic           tx_valid,
  output logic           tx_ready,
  output logic           sclk,
  output logic           sdata,
  output logic           sen,
  output logic           busy,
  output logic           done
);

  localparam int DW = $clog2(DIV + 1);
  localparam int BW = $clog2(MSB + 1);
  localparam logic [DW-1:0] DIV_LOAD = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LOAD = BW'(MSB - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, HOLD} state_t;

  state_t         state_q, state_d;
  logic [DW-1:0]  div_cnt_q, div_cnt_d;
  logic [BW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [MSB-1:0] shift_q, shift_d;
  logic           tx_ready_q, tx_ready_d;
  logic           sclk_q, sclk_d;
  logic           sdata_q, sdata_d;
  logic           sen_q, sen_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_ready_d = tx_ready_q;
    sclk_d     = sclk_q;
    sdata_d    = sdata_q;
    sen_d      = sen_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (tx_valid && tx_ready_q) begin
          // The first bit goes straight to sdata; the shift word keeps the rest.
          state_d    = LOW;
          shift_d    = tx_data << 1;
          sdata_d    = tx_data[MSB-1];
          div_cnt_d  = DIV_LOAD;
          bit_cnt_d  = BIT_LOAD;
          tx_ready_d = 1'b0;
          busy_d     = 1'b1;
          sen_d      = 1'b0;
          sclk_d     = 1'b0;
        end
      end
      LOW: begin
        if (div_cnt_q == '0) begin
          state_d   = HIGH;
          sclk_d    = 1'b1;
          div_cnt_d = DIV_LOAD;
        end else begin
          div_cnt_d = div_cnt_q - 1'b1;
        end
      end
      HIGH: begin
        if (div_cnt_q == '0) begin
          sclk_d    = 1'b0;
          div_cnt_d = DIV_LOAD;
          if (bit_cnt_q != '0) begin
            state_d   = LOW;
            sdata_d   = shift_q[MSB-1];
            shift_d   = shift_q << 1;
            bit_cnt_d = bit_cnt_q - 1'b1;
          end else begin
            state_d = HOLD;
          end
        end else begin
          div_cnt_d = div_cnt_q - 1'b1;
        end
      end
      HOLD: begin
        if (div_cnt_q == '0) begin
          state_d    = IDLE;
          sen_d      = 1'b1;
          busy_d     = 1'b0;
          tx_ready_d = 1'b1;
          done_d     = 1'b1;
        end else begin
          div_cnt_d = div_cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_ready_q <= 1'b1;
      sclk_q     <= 1'b0;
      sdata_q    <= 1'b0;
      sen_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_ready_q <= tx_ready_d;
      sclk_q     <= sclk_d;
      sdata_q    <= sdata_d;
      sen_q      <= sen_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx_ready = tx_ready_q;
  assign sclk     = sclk_q;
  assign sdata    = sdata_q;
  assign sen      = sen_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_led_serial_tx.sv
// Bench for led_serial_tx: three instances (8/2, 8/1, 16/3), a downstream shift-register
// model per instance, and a scoreboard of expected frames.
module tb_led_serial_tx;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  txd0 = '0, txd1 = '0;
  logic [15:0] txd2 = '0;
  logic [2:0]  valid_v = '0;
  logic [2:0]  ready_v, sclk_v, sdata_v, sen_v, busy_v, done_v;

  led_serial_tx #(.MSB(8), .DIV(2)) u0 (
    .clk(clk), .reset(reset), .tx_data(txd0), .tx_valid(valid_v[0]), .tx_ready(ready_v[0]),
    .sclk(sclk_v[0]), .sdata(sdata_v[0]), .sen(sen_v[0]), .busy(busy_v[0]), .done(done_v[0]));
  led_serial_tx #(.MSB(8), .DIV(1)) u1 (
    .clk(clk), .reset(reset), .tx_data(txd1), .tx_valid(valid_v[1]), .tx_ready(ready_v[1]),
    .sclk(sclk_v[1]), .sdata(sdata_v[1]), .sen(sen_v[1]), .busy(busy_v[1]), .done(done_v[1]));
  led_serial_tx #(.MSB(16), .DIV(3)) u2 (
    .clk(clk), .reset(reset), .tx_data(txd2), .tx_valid(valid_v[2]), .tx_ready(ready_v[2]),
    .sclk(sclk_v[2]), .sdata(sdata_v[2]), .sen(sen_v[2]), .busy(busy_v[2]), .done(done_v[2]));

  typedef struct {
    int          k;
    logic [15:0] data;
    int          len;
    int          rises;
  } frame_t;

  frame_t sb[$];
  int tests = 0;
  int fails = 0;

  // Per-instance downstream model state
  logic [15:0] shreg [3];
  int senlow [3], senhigh [3], gap [3], rises [3], done_cnt [3];
  int n_acc [3], n_abt [3];
  bit prev_sclk [3], abort [3];

  localparam int LEN [3] = '{34, 17, 99};
  localparam int RIS [3] = '{8, 8, 16};

  task automatic check(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s inst%0d: got %0h expected %0h", name, k, got, exp);
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      shreg[k] = '0; senlow[k] = 0; senhigh[k] = 0; gap[k] = 0; rises[k] = 0;
      done_cnt[k] = 0; n_acc[k] = 0; n_abt[k] = 0; prev_sclk[k] = 0; abort[k] = 0;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (done_v[k]) begin
        done_cnt[k]++;
        check("done_at_frame_end", k, {31'd0, sen_v[k] && senlow[k] > 0 && !abort[k]}, 32'd1);
      end
      if (!sen_v[k]) begin
        if (senlow[k] == 0) gap[k] = senhigh[k];
        senhigh[k] = 0;
        senlow[k]++;
        if (sclk_v[k] && !prev_sclk[k]) begin
          rises[k]++;
          shreg[k] = {shreg[k][14:0], sdata_v[k]};
        end
      end else begin
        if (senlow[k] > 0) begin
          if (abort[k]) begin
            check("abort_outputs", k, {27'd0, sen_v[k], sclk_v[k], ready_v[k], done_v[k], busy_v[k]},
                  32'b10100);
            if (sb.size() > 0) void'(sb.pop_front());
            abort[k] = 0;
          end else if (sb.size() == 0) begin
            check("unexpected_frame", k, 32'd1, 32'd0);
          end else begin
            frame_t e;
            logic [15:0] mask;
            e = sb.pop_front();
            mask = (k == 2) ? 16'hFFFF : 16'h00FF;
            check("frame_instance", k, e.k, k);
            check("rx_word", k, {16'd0, shreg[k] & mask}, {16'd0, e.data});
            check("sen_low_cycles", k, senlow[k], e.len);
            check("sclk_rises", k, rises[k], e.rises);
            check("done_pulse", k, {31'd0, done_v[k]}, 32'd1);
          end
        end
        senhigh[k]++;
        senlow[k] = 0;
        rises[k] = 0;
        shreg[k] = '0;
      end
      prev_sclk[k] = sclk_v[k];
    end
  end

  task automatic set_data(input int k, input logic [15:0] d);
    case (k)
      0: txd0 = d[7:0];
      1: txd1 = d[7:0];
      default: txd2 = d;
    endcase
  endtask

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic send(input int k, input logic [15:0] d, input bit hold_valid, input int len, input int ris);
    bit ok = 0;
    set_data(k, d);
    valid_v[k] = 1'b1;
    for (int n = 0; n < 400 && !ok; n++) begin
      if (ready_v[k]) begin
        frame_t e;
        e.k = k; e.data = d; e.len = len; e.rises = ris;
        @(posedge clk);
        sb.push_back(e);
        n_acc[k]++;
        ok = 1;
      end else begin
        @(posedge clk);
      end
      @(negedge clk); #1;
    end
    if (!ok) check("accept_timeout", k, 32'd0, 32'd1);
    if (!hold_valid) valid_v[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    bit ok = 0;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge clk); #1;
      if (ready_v[k] && sen_v[k] && !done_v[k]) ok = 1;
    end
    if (!ok) check("idle_timeout", k, 32'd0, 32'd1);
  endtask

  initial begin
    frame_t vec [5];
    int d0;
    bit ok;
    vec[0] = '{0, 16'h00A5, 34, 8};
    vec[1] = '{1, 16'h0000, 17, 8};
    vec[2] = '{1, 16'h00FF, 17, 8};
    vec[3] = '{1, 16'h0055, 17, 8};
    vec[4] = '{2, 16'h8001, 99, 16};

    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++)
      check("reset_state", k, {26'd0, ready_v[k], busy_v[k], sen_v[k], sclk_v[k], sdata_v[k], done_v[k]},
            32'b101000);
    reset = 1'b1;
    @(negedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      send(vec[i].k, vec[i].data, 0, vec[i].len, vec[i].rises);
      wait_idle(vec[i].k);
    end

    // Back-to-back with tx_valid held across both words
    d0 = done_cnt[0];
    send(0, 16'h003C, 1, LEN[0], RIS[0]);
    send(0, 16'h00C3, 0, LEN[0], RIS[0]);
    wait_idle(0);
    check("b2b_sen_gap", 0, gap[0], 1);
    check("b2b_done_count", 0, done_cnt[0] - d0, 2);

    // Valid toggling and data changing while busy must be ignored
    send(0, 16'h0012, 0, LEN[0], RIS[0]);
    txd0 = 8'hFF;
    for (int n = 0; n < 20; n++) begin
      valid_v[0] = ~valid_v[0];
      @(negedge clk); #1;
      check("ready_low_busy", 0, {31'd0, ready_v[0]}, 32'd0);
    end
    valid_v[0] = 1'b0;
    wait_idle(0);

    // Reset after the third sclk rise aborts the frame
    send(0, 16'h0081, 0, LEN[0], RIS[0]);
    ok = 0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk); #1;
      if (rises[0] == 3) ok = 1;
    end
    if (!ok) check("third_rise_timeout", 0, 32'd0, 32'd1);
    abort[0] = 1;
    n_abt[0]++;
    reset = 1'b0;
    @(negedge clk); #1;
    reset = 1'b1;
    send(0, 16'h007E, 0, LEN[0], RIS[0]);
    wait_idle(0);

    repeat (3) @(negedge clk);
    #1;
    check("scoreboard_empty", 0, sb.size(), 0);
    for (int k = 0; k < 3; k++)
      check("done_total", k, done_cnt[k], n_acc[k] - n_abt[k]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1);
  end

endmodule
